// File: rtl/nios2_leds_out.sv
// Memory-mapped LED output port with a DATA register, set/clear aliases and a
// self-expiring PULSE overlay XORed onto the LEDs for PULSE_CYCLES clocks.
module nios2_leds_out #(
    parameter int          WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'd0,
    parameter int          PULSE_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_PULSE    = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    logic [WIDTH-1:0] data_p0;
    logic [WIDTH-1:0] pulse_p0;
    logic [CNT_W-1:0] cnt_p0;

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             unused_writedata;

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];
    assign busy  = (cnt_p0 != '0);

    // Bits of writedata above WIDTH are deliberately dropped.
    assign unused_writedata = ^writedata;

    // Busy flag occupies bit 31 and wins over PULSE[31] when WIDTH is 32.
    function automatic logic [31:0] read_word(
        input logic [1:0]       addr,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] p,
        input logic             b
    );
        logic [31:0] w;
        w = '0;
        case (addr)
            ADDR_DATA:  w = 32'(d);
            ADDR_PULSE: begin
                w     = 32'(p);
                w[31] = b;
            end
            default:    w = '0;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            data_p0  <= RESET_VALUE[WIDTH-1:0];
            pulse_p0 <= '0;
            cnt_p0   <= '0;
            readdata <= '0;
        end else begin
            if (wr) begin
                case (address)
                    ADDR_DATA:     data_p0 <= wdata;
                    ADDR_OUTSET:   data_p0 <= data_p0 | wdata;
                    ADDR_OUTCLEAR: data_p0 <= data_p0 & ~wdata;
                    default:       data_p0 <= data_p0;
                endcase
            end

            // A PULSE write (restart or abort) overrides countdown and expiry.
            if (wr && address == ADDR_PULSE) begin
                if (wdata != '0) begin
                    pulse_p0 <= wdata;
                    cnt_p0   <= CNT_LOAD;
                end else begin
                    pulse_p0 <= '0;
                    cnt_p0   <= '0;
                end
            end else if (busy) begin
                cnt_p0 <= cnt_p0 - CNT_ONE;
                if (cnt_p0 == CNT_ONE)
                    pulse_p0 <= '0;
            end

            readdata <= read_word(address, data_p0, pulse_p0, busy);
        end
    end

    assign out_port = data_p0 ^ pulse_p0;

endmodule

// File: tb/tb_nios2_leds_out.sv
// Bench for nios2_leds_out: directed vector table followed by random traffic
// checked against a cycle-count based behavioural model.
module tb_nios2_leds_out;

    localparam int          W  = 8;
    localparam int          PC = 4;
    localparam logic [31:0] RV = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] out_port;

    nios2_leds_out #(
        .WIDTH(W),
        .RESET_VALUE(RV),
        .PULSE_CYCLES(PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the pulse is visible while the edge count is below m_end.
    int          ecount = 0;
    int          m_end  = 0;
    logic [W-1:0] m_data = RV[W-1:0];
    logic [W-1:0] m_pval = '0;
    logic [31:0] m_rd   = '0;

    function automatic logic m_busy();
        return ecount < m_end;
    endfunction

    function automatic logic [W-1:0] m_pulse();
        return m_busy() ? m_pval : '0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_data};
            2'd1:    return {m_busy(), 23'h0, m_pulse()};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic w,
                        input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rd_next;
        reset = r; chipselect = c; write_n = w; address = a; writedata = d;
        @(posedge clk);
        rd_next = m_read(a);
        ecount++;
        if (r) begin
            m_data  = RV[W-1:0];
            m_end   = 0;
            rd_next = 32'h0;
        end else if (c && !w) begin
            case (a)
                2'd0: m_data = d[W-1:0];
                2'd2: m_data = m_data | d[W-1:0];
                2'd3: m_data = m_data & ~d[W-1:0];
                default: begin
                    if (d[W-1:0] != '0) begin
                        m_pval = d[W-1:0];
                        m_end  = ecount + PC;
                    end else begin
                        m_end  = 0;
                    end
                end
            endcase
        end
        m_rd = rd_next;
        @(negedge clk);
        chk("model_out_port", 32'(out_port), 32'(m_data ^ m_pulse()));
        chk("model_readdata", readdata, m_rd);
    endtask

    typedef struct {
        logic        rst;
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic c, input logic w,
                                input logic [1:0] a, input logic [31:0] d,
                                input logic [7:0] o, input logic [31:0] rd);
        vec_t v;
        v.rst = r; v.cs = c; v.wn = w; v.addr = a; v.wd = d;
        v.exp_out = o; v.exp_rd = rd;
        return v;
    endfunction

    function automatic vec_t wr(input logic [1:0] a, input logic [31:0] d,
                                input logic [7:0] o, input logic [31:0] rd);
        return mk(1'b0, 1'b1, 1'b0, a, d, o, rd);
    endfunction

    function automatic vec_t idle(input logic [1:0] a, input logic [7:0] o,
                                  input logic [31:0] rd);
        return mk(1'b0, 1'b0, 1'b1, a, 32'h0, o, rd);
    endfunction

    vec_t tbl[34];

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0;

        // Reset and readback of RESET_VALUE
        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 8'hA5, 32'h0);
        tbl[1]  = idle(2'd0, 8'hA5, 32'h0000_00A5);
        // DATA / OUTSET / OUTCLEAR, upper writedata bits ignored
        tbl[2]  = wr(2'd0, 32'hFFFF_FF0F, 8'h0F, 32'h0000_00A5);
        tbl[3]  = wr(2'd2, 32'h1234_56F0, 8'hFF, 32'h0);
        tbl[4]  = wr(2'd3, 32'hABCD_EF3C, 8'hC3, 32'h0);
        tbl[5]  = idle(2'd0, 8'hC3, 32'h0000_00C3);
        // Single pulse of exactly PC cycles
        tbl[6]  = wr(2'd0, 32'h0, 8'h00, 32'h0000_00C3);
        tbl[7]  = wr(2'd1, 32'h81, 8'h81, 32'h0);
        tbl[8]  = idle(2'd1, 8'h81, 32'h8000_0081);
        tbl[9]  = idle(2'd1, 8'h81, 32'h8000_0081);
        tbl[10] = idle(2'd1, 8'h81, 32'h8000_0081);
        tbl[11] = idle(2'd1, 8'h00, 32'h8000_0081);
        tbl[12] = idle(2'd1, 8'h00, 32'h0);
        // Restart on the third busy cycle
        tbl[13] = wr(2'd1, 32'h01, 8'h01, 32'h0);
        tbl[14] = idle(2'd1, 8'h01, 32'h8000_0001);
        tbl[15] = idle(2'd1, 8'h01, 32'h8000_0001);
        tbl[16] = wr(2'd1, 32'h02, 8'h02, 32'h8000_0001);
        tbl[17] = idle(2'd1, 8'h02, 32'h8000_0002);
        tbl[18] = idle(2'd1, 8'h02, 32'h8000_0002);
        tbl[19] = idle(2'd1, 8'h02, 32'h8000_0002);
        tbl[20] = idle(2'd1, 8'h00, 32'h8000_0002);
        // Restart in the expiry cycle, then abort with zero
        tbl[21] = wr(2'd1, 32'h01, 8'h01, 32'h0);
        tbl[22] = idle(2'd1, 8'h01, 32'h8000_0001);
        tbl[23] = idle(2'd1, 8'h01, 32'h8000_0001);
        tbl[24] = idle(2'd1, 8'h01, 32'h8000_0001);
        tbl[25] = wr(2'd1, 32'h01, 8'h01, 32'h8000_0001);
        tbl[26] = idle(2'd1, 8'h01, 32'h8000_0001);
        tbl[27] = wr(2'd1, 32'hFFFF_FF00, 8'h00, 32'h8000_0001);
        tbl[28] = idle(2'd1, 8'h00, 32'h0);
        // Reset mid-pulse overrides a simultaneous DATA write
        tbl[29] = wr(2'd1, 32'h81, 8'h81, 32'h0);
        tbl[30] = idle(2'd1, 8'h81, 32'h8000_0081);
        tbl[31] = mk(1'b1, 1'b1, 1'b0, 2'd0, 32'h11, 8'hA5, 32'h0);
        tbl[32] = idle(2'd1, 8'hA5, 32'h0);
        tbl[33] = idle(2'd0, 8'hA5, 32'h0000_00A5);

        for (int i = 0; i < 34; i++) begin
            step(tbl[i].rst, tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd);
            chk($sformatf("vec%0d_out_port", i), 32'(out_port), 32'(tbl[i].exp_out));
            chk($sformatf("vec%0d_readdata", i), readdata, tbl[i].exp_rd);
        end

        for (int i = 0; i < 600; i++) begin
            logic        r, c, w;
            logic [1:0]  a;
            logic [31:0] d;
            r = ($urandom_range(0, 40) == 0);
            c = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 3) == 0)
                d[7:0] = 8'h00;
            step(r, c, w, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios2_leds_out.md
NIOS2_LEDS_OUT -- requirements
Module: nios2_leds_out

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of output bits, range 1..32.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0: value loaded into the data register at reset.
REQ-003 The block SHALL have parameter PULSE_CYCLES, default 50000000: pulse duration in clk cycles, at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 The block SHALL have port address, input, 2 bits: register select.
REQ-007 The block SHALL have port chipselect, input, 1 bit: slave selected.
REQ-008 The block SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port out_port, output, WIDTH bits: drives the board LEDs.

Function
REQ-012 The block SHALL hold two registers: DATA (WIDTH bits) and PULSE (WIDTH bits), plus a pulse down-counter CNT of width clog2(PULSE_CYCLES+1).
REQ-013 A write SHALL be defined as chipselect=1 and write_n=0 at a rising edge; a write takes effect at that edge.
REQ-014 Address map SHALL be: 0 = DATA (R/W); 1 = PULSE (R/W); 2 = OUTSET (W); 3 = OUTCLEAR (W).
REQ-015 A write to address 0 SHALL load DATA with writedata[WIDTH-1:0].
REQ-016 A write to address 2 SHALL set DATA to DATA OR writedata[WIDTH-1:0].
REQ-017 A write to address 3 SHALL set DATA to DATA AND NOT writedata[WIDTH-1:0].
REQ-018 A write to address 1 with nonzero writedata[WIDTH-1:0] SHALL load PULSE with that value and CNT with PULSE_CYCLES, restarting any active pulse.
REQ-019 A write to address 1 with zero writedata[WIDTH-1:0] SHALL clear PULSE and CNT, aborting any active pulse.
REQ-020 When CNT is nonzero and no write to address 1 occurs, CNT SHALL decrement by 1 per cycle.
REQ-021 When CNT decrements from 1 to 0, PULSE SHALL clear at the same edge; PULSE is therefore nonzero for exactly PULSE_CYCLES cycles.
REQ-022 A write to address 1 in the expiry cycle SHALL take priority over expiry.
REQ-023 Writes to addresses 0, 2 and 3 SHALL NOT affect PULSE or CNT, and pulse expiry SHALL NOT affect DATA.
REQ-024 out_port SHALL equal DATA XOR PULSE, with only combinational XOR after the registers; a change is visible in the cycle after the write edge.
REQ-025 readdata SHALL be registered every cycle, independent of chipselect, giving one cycle of latency.
REQ-026 readdata by address SHALL be: address 0 = DATA zero-extended; address 1 = PULSE zero-extended with bit 31 = busy (CNT != 0); addresses 2 and 3 = 0.
REQ-027 When WIDTH=32, busy SHALL take priority over PULSE bit 31 in bit 31 of readdata at address 1.
REQ-028 writedata bits at and above WIDTH SHALL be ignored on every register write.

Reset
REQ-029 While reset=1 at an edge, the block SHALL set DATA=RESET_VALUE[WIDTH-1:0], PULSE=0, CNT=0 and readdata=0, overriding any simultaneous write.
REQ-030 Reset during an active pulse SHALL abort it immediately; after reset, out_port SHALL equal RESET_VALUE.

Verification (bench parameters: WIDTH=8, PULSE_CYCLES=4, RESET_VALUE=8'hA5)
REQ-031 Reset, then read address 0 -> out_port=8'hA5; readdata=32'h000000A5 one cycle after address is applied.
REQ-032 Write 0 <- 8'h0F, then write 2 <- 8'hF0, then write 3 <- 8'h3C -> out_port 8'h0F, 8'hFF, 8'hC3 on successive cycles.
REQ-033 With DATA=8'h00, write 1 <- 8'h81 -> out_port=8'h81 for exactly 4 cycles, then 8'h00; address 1 reads 32'h80000081 while busy and 32'h0 after.
REQ-034 Write 1 <- 8'h01, then write 1 <- 8'h02 on the 3rd busy cycle -> out_port shows 8'h02 for a further 4 full cycles.
REQ-035 Write 1 <- 8'h01 in the expiry cycle of a pulse -> pulse restarts with no idle cycle; a write of 8'h00 to address 1 mid-pulse clears busy next cycle.
REQ-036 Assert reset mid-pulse together with write 0 <- 8'h11 -> out_port=8'hA5, busy=0, and the write is ignored.
